ysyx_220066_alu_issue: RTL and testbench

//  Execute-stage initiator for the ysyx_220066 64-bit ALU. Accepts decoded RV64I integer ops

---
 rtl/ysyx_220066_alu_pkg.sv | 28 ++
 rtl/ysyx_220066_alu_encode.sv | 69 ++++++
 rtl/ysyx_220066_alu_issue.sv | 119 +++++++++++
 tb/tb_ysyx_220066_alu_issue.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_alu_pkg.sv
// Shared encodings and the stage-A request record for the ysyx_220066 ALU issue block.
package ysyx_220066_alu_pkg;

  localparam int ALU_XLEN = 64;
  localparam int ALU_RDW  = 5;
  localparam int CTR_W    = 5;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SLL   = 3'd1;
  localparam logic [2:0] ALU_SLT   = 3'd2;
  localparam logic [2:0] ALU_COPYB = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SR    = 3'd5;
  localparam logic [2:0] ALU_OR    = 3'd6;
  localparam logic [2:0] ALU_AND   = 3'd7;

  localparam int CTR_SUB_BIT = 3;
  localparam int CTR_W_BIT   = 4;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [CTR_W-1:0]    ctr;
    logic [ALU_RDW-1:0]  rd;
    logic                is_w;
  } alu_req_t;

endpackage

// File: rtl/ysyx_220066_alu_encode.sv
// Combinational decode of RV64I integer-op fields into the ALU control word and operand B.
module ysyx_220066_alu_encode
  import ysyx_220066_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            is_w,
  input  logic            is_imm,
  input  logic            is_lui,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic [CTR_W-1:0] ctr,
  output logic [XLEN-1:0] b
);

  logic [2:0] op;
  logic       sub;
  logic       word;

  always_comb begin
    op   = ALU_ADD;
    sub  = 1'b0;
    word = 1'b0;
    case (funct3)
      3'b000: begin
        op   = ALU_ADD;
        sub  = alt & ~is_imm;  // ADDI/ADDIW carry funct7 bits in the immediate
        word = is_w;
      end
      3'b001: begin
        op   = ALU_SLL;
        word = is_w;
      end
      3'b010: begin
        op  = ALU_SLT;
        sub = 1'b1;
      end
      3'b011: op = ALU_SLT;
      3'b100: op = ALU_XOR;
      3'b101: begin
        op   = ALU_SR;
        sub  = alt;
        word = is_w;
      end
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase

    if (is_lui) begin
      op   = ALU_COPYB;
      sub  = 1'b0;
      word = 1'b0;
    end

    b = (is_imm | is_lui) ? imm : rs2;
    // Word shifts only honour a 5-bit shift amount.
    if (word && (op == ALU_SLL || op == ALU_SR)) b[5] = 1'b0;
  end

  always_comb begin
    ctr                 = '0;
    ctr[2:0]            = op;
    ctr[CTR_SUB_BIT]    = sub;
    ctr[CTR_W_BIT]      = word;
  end

endmodule

// File: rtl/ysyx_220066_alu_issue.sv
// Execute-stage initiator: request register -> external comb ALU -> output register,
// with a valid/ready handshake on both sides and W-op sign extension at capture.
module ysyx_220066_alu_issue
  import ysyx_220066_alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic            in_is_w,
  input  logic            in_is_imm,
  input  logic            in_is_lui,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RDW-1:0]  in_rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RDW-1:0]  out_rd
);

  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  logic             vld_p0;
  alu_req_t         req_p0;
  logic             vld_p1;
  logic [XLEN-1:0]  res_p1;
  logic [RDW-1:0]   rd_p1;

  logic             o_adv;
  logic             a_adv;
  logic             accept;
  logic [CTR_W-1:0] enc_ctr;
  logic [XLEN-1:0]  enc_b;

  assign o_adv    = ~vld_p1 | out_ready;
  assign a_adv    = vld_p0 & o_adv;
  assign in_ready = ~flush & (~vld_p0 | o_adv);
  assign accept   = in_valid & in_ready;

  ysyx_220066_alu_encode #(
    .XLEN(XLEN)
  ) u_encode (
    .funct3 (in_funct3),
    .alt    (in_alt),
    .is_w   (in_is_w),
    .is_imm (in_is_imm),
    .is_lui (in_is_lui),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .ctr    (enc_ctr),
    .b      (enc_b)
  );

  // Stage A: registered request driving the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      req_p0 <= '0;
    end else begin
      if (flush)       vld_p0 <= 1'b0;
      else if (accept) vld_p0 <= 1'b1;
      else if (a_adv)  vld_p0 <= 1'b0;

      if (accept) begin
        req_p0.a    <= in_rs1;
        req_p0.b    <= enc_b;
        req_p0.ctr  <= enc_ctr;
        req_p0.rd   <= in_rd;
        req_p0.is_w <= enc_ctr[CTR_W_BIT];
      end
    end
  end

  assign alu_a   = req_p0.a;
  assign alu_b   = req_p0.b;
  assign alu_ctr = req_p0.ctr;

  // Stage O: captured result toward writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      rd_p1  <= '0;
    end else begin
      if (flush)      vld_p1 <= 1'b0;
      else if (o_adv) vld_p1 <= vld_p0;

      if (a_adv && !flush) begin
        res_p1 <= req_p0.is_w ? sext_word(alu_result[31:0]) : alu_result;
        rd_p1  <= req_p0.rd;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = res_p1;
  assign out_rd     = rd_p1;

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_p1 && !out_ready && !flush) |=> (vld_p1 && $stable(res_p1) && $stable(rd_p1)));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_p0 && !a_adv && !flush) |=> (vld_p0 && $stable(req_p0)));

endmodule

// File: tb/tb_ysyx_220066_alu_issue.sv
// Scoreboard bench for the ALU issue block with a behavioural 64-bit ALU on alu_*.
module tb_ysyx_220066_alu_issue;

  typedef struct packed {
    logic [2:0]  f3;
    logic        alt;
    logic        w;
    logic        imm_f;
    logic        lui;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic        in_is_w = 1'b0;
  logic        in_is_imm = 1'b0;
  logic        in_is_lui = 1'b0;
  logic [63:0] in_rs1 = '0;
  logic [63:0] in_rs2 = '0;
  logic [63:0] in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_ctr;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic rnd_done;

  always #5 clk = ~clk;

  ysyx_220066_alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_alt     (in_alt),
    .in_is_w    (in_is_w),
    .in_is_imm  (in_is_imm),
    .in_is_lui  (in_is_lui),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_rd      (in_rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctr    (alu_ctr),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  // Behavioural ALU: word mode yields a zero-extended 32-bit result and uses the full b[5:0].
  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] ctr);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    case (ctr[2:0])
      3'd0: begin
        t = ctr[3] ? a - b : a + b;
        r = ctr[4] ? {32'b0, t[31:0]} : t;
      end
      3'd1: begin
        t = a << b[5:0];
        r = ctr[4] ? {32'b0, t[31:0]} : t;
      end
      3'd2: begin
        if (ctr[3]) r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        else        r = (a < b) ? 64'd1 : 64'd0;
      end
      3'd3: r = b;
      3'd4: r = a ^ b;
      3'd5: begin
        if (ctr[4]) begin
          if (ctr[3]) t = $signed({{32{a[31]}}, a[31:0]}) >>> b[5:0];
          else        t = {32'b0, a[31:0]} >> b[5:0];
          r = {32'b0, t[31:0]};
        end else begin
          if (ctr[3]) r = $signed(a) >>> b[5:0];
          else        r = a >> b[5:0];
        end
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_ctr);

  // Architectural RV64I reference for the expected writeback value.
  function automatic logic [63:0] ref_op(input op_t o);
    logic [63:0] b;
    logic [63:0] r;
    logic [31:0] r32;
    b = (o.imm_f | o.lui) ? o.imm : o.rs2;
    r = '0;
    if (o.lui) return o.imm;
    case (o.f3)
      3'd0: begin
        if (o.w) begin
          if (o.alt && !o.imm_f) r32 = o.rs1[31:0] - b[31:0];
          else                   r32 = o.rs1[31:0] + b[31:0];
          r = {{32{r32[31]}}, r32};
        end else begin
          r = (o.alt && !o.imm_f) ? o.rs1 - b : o.rs1 + b;
        end
      end
      3'd1: begin
        if (o.w) begin
          r32 = o.rs1[31:0] << b[4:0];
          r = {{32{r32[31]}}, r32};
        end else r = o.rs1 << b[5:0];
      end
      3'd2: r = ($signed(o.rs1) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r = (o.rs1 < b) ? 64'd1 : 64'd0;
      3'd4: r = o.rs1 ^ b;
      3'd5: begin
        if (o.w) begin
          if (o.alt) r32 = $signed(o.rs1[31:0]) >>> b[4:0];
          else       r32 = o.rs1[31:0] >> b[4:0];
          r = {{32{r32[31]}}, r32};
        end else begin
          if (o.alt) r = $signed(o.rs1) >>> b[5:0];
          else       r = o.rs1 >> b[5:0];
        end
      end
      3'd6: r = o.rs1 | b;
      default: r = o.rs1 & b;
    endcase
    return r;
  endfunction

  function automatic op_t mk(input logic [2:0] f3, input logic alt, input logic w,
                             input logic imm_f, input logic lui, input logic [63:0] rs1,
                             input logic [63:0] rs2, input logic [63:0] imm,
                             input logic [4:0] rd);
    op_t o;
    o.f3 = f3; o.alt = alt; o.w = w; o.imm_f = imm_f; o.lui = lui;
    o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.rd = rd;
    return o;
  endfunction

  function automatic op_t rnd_op(input int k);
    op_t o;
    logic [31:0] r;
    logic [31:0] s;
    r = $urandom;
    s = $urandom;
    o.f3 = r[2:0]; o.alt = r[3]; o.w = r[4]; o.imm_f = r[5];
    o.lui = (r[8:6] == 3'd0);
    o.rd = r[13:9];
    o.imm = {{52{r[31]}}, r[31:20]};
    o.rs1 = (k % 5 == 0) ? 64'h0000_0000_8000_0000 : {$urandom, s};
    o.rs2 = (k % 3 == 0) ? {58'b0, s[5:0]} : {s, $urandom};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send(input op_t o);
    int n;
    exp_t e;
    n = 0;
    in_funct3 = o.f3; in_alt = o.alt; in_is_w = o.w; in_is_imm = o.imm_f;
    in_is_lui = o.lui; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_rd = o.rd;
    in_valid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        e.rd = o.rd;
        e.res = ref_op(o);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] exp, input logic [4:0] rd);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk(tag, out_result, exp);
      chk({tag, "_rd"}, 64'(out_rd), 64'(rd));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_res", out_result, e.res);
        chk("sb_rd", 64'(out_rd), 64'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_alu_ctr", 64'(alu_ctr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADDW overflow, with latency observation
    send(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0, 5'd1));
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    chk("addw", out_result, 64'hFFFF_FFFF_8000_0000);
    @(posedge clk); #1;

    send(mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 5'd2));
    chk("sub_ctr", 64'(alu_ctr), 64'(5'b01000));
    expect_out("sub", 64'hFFFF_FFFF_FFFF_FFFE, 5'd2);
    send(mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, '1, 64'd0, 5'd3));
    expect_out("sltu", 64'd1, 5'd3);
    send(mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, '1, 64'd0, 5'd4));
    expect_out("slt", 64'd0, 5'd4);
    send(mk(3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'd4, 5'd5));
    expect_out("sraiw", 64'hFFFF_FFFF_F800_0000, 5'd5);
    send(mk(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h24, 64'd0, 5'd6));
    expect_out("srlw", 64'h0000_0000_0800_0000, 5'd6);
    send(mk(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 64'd10, 64'd99, 64'd3, 5'd7));
    expect_out("addi_alt", 64'd13, 5'd7);

    // Back-to-back with a 3-cycle writeback stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'(100 + i), 64'(i), 64'd0, 5'(10 + i)));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_rd", 64'(out_rd), 64'd10);
        chk("stall_out_result", out_result, 64'd100);
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Flush with two ops in flight; an op offered during flush must be dropped
    out_ready = 1'b0;
    send(mk(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'd0, 5'd20));
    send(mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFF, 64'h3C, 64'd0, 5'd21));
    flush = 1'b1;
    in_valid = 1'b1;
    in_rd = 5'd22;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("flush_no_accept", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 64'hAA, 64'h0F, 64'd0, 5'd9));
    expect_out("post_flush", 64'hA5, 5'd9);

    // Reset mid-flight
    out_ready = 1'b0;
    send(mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd8, 64'd0, 5'd23));
    send(mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd9, 64'd0, 5'd24));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_result", out_result, 64'd0);
    chk("midrst_out_rd", 64'(out_rd), 64'd0);
    chk("midrst_alu_a", alu_a, 64'd0);
    chk("midrst_alu_b", alu_b, 64'd0);
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_still_empty", 64'(out_valid), 64'd0);
    send(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD, 64'hBEEF, 64'h1234_5000, 5'd25));
    expect_out("lui", 64'h1234_5000, 5'd25);

    // Random ops with random writeback backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) send(rnd_op(k));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
